hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller that consumes the per-instruction control bits produced by the ID-stage decoder and turns them into stall, bubble, flush and forwarding-select signals for the 5-stage forwarding CPU. It keeps its own shadow copy of the destination and read-set tags for the instructions in EX, MEM and WB, so hazard decisions need no other pipeline registers. It sits beside the datapath and drives the PC/IF-ID write enables, the ID/EX bubble mux and the EX operand muxes.

## Interface
- CNT_W, 16, width of the saturating performance counters
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (0 after flush)
- id_rs, id_rt  in  5 each  source register fields of the ID instruction
- id_read_rs, id_read_rt  in  1 each  decoder read flags
- id_dest  in  5  final destination (RegDst/SavePC already applied; 31 for JAL)
- id_reg_write, id_mem_read  in  1 each  decoder RegWrite / MemRead
- id_jump  in  1  J/JAL, resolved in ID
- ex_redirect  in  1  branch taken or JR resolved in EX this cycle
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- flush_if_id  out  1  zero IF/ID on next edge
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Shadow stages EX, MEM, WB each hold: valid, dest, reg_write, mem_read, rs, rt, read_rs, read_rt.
- Every edge: WB<=MEM, MEM<=EX, EX<=ID tags, except EX<=bubble (all fields 0) when bubble=1.
- Load-use: stall=bubble=1 when id_valid & EX.mem_read & EX.reg_write & EX.dest!=0 & ((id_read_rs & id_rs==EX.dest) | (id_read_rt & id_rt==EX.dest)). One cycle; the load then sits in MEM and the condition clears.
- Redirect: ex_redirect=1 -> flush_if_id=1, bubble=1, stall=0 (flush has priority over load-use stall).
- Jump: id_jump & id_valid & !ex_redirect -> flush_if_id=1 only; ID instruction proceeds normally.
- Forwarding A (B identical with rt/read_rt): if EX.read_rs & EX.rs!=0 & MEM.reg_write & MEM.dest==EX.rs -> 01; else if WB.reg_write & WB.dest==EX.rs (same qualifiers) -> 10; else 00. MEM wins over WB.
- Register 0 never causes stall or forwarding.
- WB-to-ID same-cycle conflicts: none; regfile is write-through.
- stall_cnt increments on each cycle with stall=1; flush_cnt on each cycle with flush_if_id=1; both saturate at 2^CNT_W-1.

## Timing
- stall, bubble, flush_if_id, fwd_a/b: combinational from ID inputs and shadow registers, valid same cycle.
- Shadow tags and counters: registered, update on rising clk.
- Reset (rst=1 on edge): all shadow fields 0, counters 0; therefore all outputs 0 the cycle after reset. rst mid-stall clears the stall the next cycle.
- Simultaneous load-use and ex_redirect: redirect only; stall_cnt does not increment.
- Simultaneous id_jump and ex_redirect: one flush, flush_cnt +1.

## Structure
- Forwarding-select codes (FWD_RF=0, FWD_MEM=1, FWD_WB=2) become defines in GLOBAL.v, shared with the EX operand muxes.
- One sub-module: hazard_tag_reg, one shadow stage (tag bundle register with synchronous clear and bubble-insert input), instantiated three times.

## Test plan
- LW $2,0($1) then ADDU $3,$2,$4 -> stall=bubble=1 for exactly 1 cycle, then fwd_a=10 when ADDU reaches EX; stall_cnt=1.
- ADDU $5,$1,$1 then SUBU $6,$5,$5 -> no stall, fwd_a=fwd_b=01; one cycle later a third user of $5 sees 10.
- ADDU $0,$1,$1 then ADDU $7,$0,$0 -> fwd_a=fwd_b=00, no stall.
- BEQ taken (ex_redirect=1) while ID holds a load-use consumer -> flush_if_id=1, bubble=1, stall=0; flush_cnt=1, stall_cnt=0.
- JAL in ID -> flush_if_id=1 one cycle; id_dest=31 tracked so following ADDU $8,$31,$0 gets fwd_a=01.
- Counters forced near max (CNT_W=4, 16 stalls) -> stall_cnt holds 15; rst=1 mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types and helpers for the hazard controller: shadow tag bundle,
// forwarding-select codes and the operand forwarding priority function.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       read_rs;
        logic       read_rt;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // The younger producer in MEM beats the older one in WB; $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic rd, input logic [4:0] src,
                                           input tag_t mem, input tag_t wb);
        logic [1:0] sel;
        if (rd && (src != 5'd0) && mem.reg_write && (mem.dest == src)) begin
            sel = FWD_MEM;
        end else if (rd && (src != 5'd0) && wb.reg_write && (wb.dest == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_tag_reg.sv
// One shadow pipeline stage: tag bundle register with synchronous reset and
// a bubble-insert clear that loads an all-zero tag.
module hazard_tag_reg
    import hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o
);

    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_d;

    // Next tag: a bubble is indistinguishable from an empty slot.
    always_comb begin
        tag_d = tag_i;
        if (clr_i) begin
            tag_d = {TAG_W{1'b0}};
        end else begin
            tag_d = tag_i;
        end
    end

    // Stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= {TAG_W{1'b0}};
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_o = tag_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage forwarding CPU: load-use stall, redirect
// and jump flush, EX operand forwarding selects and saturating event counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_read_rs,
    input  logic             id_read_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_jump,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             bubble,
    output logic             flush_if_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tag_t             id_tag_s;
    tag_t             ex_s;
    tag_t             mem_s;
    tag_t             wb_s;
    logic [TAG_W-1:0] ex_vec_s;
    logic [TAG_W-1:0] mem_vec_s;
    logic [TAG_W-1:0] wb_vec_s;
    logic             load_use_s;
    logic             stall_s;
    logic             bubble_s;
    logic             flush_s;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // ID tag capture; an invalid ID slot must not look like a producer or consumer.
    always_comb begin
        id_tag_s.valid     = id_valid;
        id_tag_s.dest      = id_dest;
        id_tag_s.reg_write = id_reg_write & id_valid;
        id_tag_s.mem_read  = id_mem_read & id_valid;
        id_tag_s.rs        = id_rs;
        id_tag_s.rt        = id_rt;
        id_tag_s.read_rs   = id_read_rs & id_valid;
        id_tag_s.read_rt   = id_read_rt & id_valid;
    end

    hazard_tag_reg u_ex (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bubble_s),
        .tag_i (id_tag_s),
        .tag_o (ex_vec_s)
    );

    hazard_tag_reg u_mem (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .tag_i (ex_vec_s),
        .tag_o (mem_vec_s)
    );

    hazard_tag_reg u_wb (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .tag_i (mem_vec_s),
        .tag_o (wb_vec_s)
    );

    assign ex_s  = ex_vec_s;
    assign mem_s = mem_vec_s;
    assign wb_s  = wb_vec_s;

    // Stall/bubble/flush decision; a redirect squashes the load-use stall.
    always_comb begin
        load_use_s = id_valid & ex_s.mem_read & ex_s.reg_write & (ex_s.dest != 5'd0) &
                     ((id_read_rs & (id_rs == ex_s.dest)) |
                      (id_read_rt & (id_rt == ex_s.dest)));
        if (ex_redirect) begin
            stall_s  = 1'b0;
            bubble_s = 1'b1;
            flush_s  = 1'b1;
        end else begin
            stall_s  = load_use_s;
            bubble_s = load_use_s;
            flush_s  = id_jump & id_valid;
        end
    end

    // Saturating counter next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall       = stall_s;
    assign bubble      = bubble_s;
    assign flush_if_id = flush_s;
    assign fwd_a       = fwd_sel(ex_s.read_rs, ex_s.rs, mem_s, wb_s);
    assign fwd_b       = fwd_sel(ex_s.read_rt, ex_s.rt, mem_s, wb_s);
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
